spike_rate_encoder: RTL

Converts a 25-pixel intensity frame into per-timestep spike vectors that drive the first network layer. It is the transmitter side of the layer input, `L_1_pexel`. Each pixel is rate-coded with a deterministic phase accumulator, so a pixel of value p fires p/256 of timesteps on average. A start/busy/done handshake frames one inference window of N_STEPS timesteps, and the window advances on the same `pulse` strobe that the layers use.

---
 rtl/snn_pkg.sv | 27 ++
 rtl/spike_enc_channel.sv | 45 ++++
 rtl/spike_rate_encoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and defaults for the spike rate encoder.
// Provides the encoder FSM enum, default sizes and the saturating adder
// used by the optional spike counter.
package snn_pkg;

    localparam int N_PIX_DEF   = 25;
    localparam int PIX_W_DEF   = 8;
    localparam int N_STEPS_DEF = 100;
    localparam int SPK_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    // Add and clamp at all-ones instead of wrapping.
    function automatic logic [SPK_CNT_W-1:0] sat_add(
        input logic [SPK_CNT_W-1:0] a,
        input logic [SPK_CNT_W-1:0] b
    );
        logic [SPK_CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SPK_CNT_W] ? {SPK_CNT_W{1'b1}} : s[SPK_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/spike_enc_channel.sv
// One rate-coding lane: latched pixel plus phase accumulator.
// Ports: clk, reset (sync, active-high), load (latch pix_in, clear acc),
// step (advance the accumulator), pix_in, spike (carry of this step's add).
module spike_enc_channel #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [PIX_W-1:0] pix_in,
    output logic             spike
);

    logic [PIX_W-1:0] pix_q, pix_d;
    logic [PIX_W-1:0] acc_q, acc_d;
    logic [PIX_W:0]   sum;

    // The carry out of acc + pix is the spike for the step being taken;
    // the top registers it so the lane itself stays combinational here.
    assign sum   = {1'b0, acc_q} + {1'b0, pix_q};
    assign spike = sum[PIX_W];

    always_comb begin
        pix_d = pix_q;
        acc_d = acc_q;
        if (load) begin
            pix_d = pix_in;
            acc_d = '0;
        end else if (step) begin
            acc_d = sum[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= '0;
            acc_q <= '0;
        end else begin
            pix_q <= pix_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes a pixel frame into per-timestep spike vectors over a window
// of N_STEPS pulses, framed by start/busy/done.
// Ports: clk, reset (sync, active-high), pulse (timestep strobe), start,
// pixels (N_PIX*PIX_W frame), spike_out, spike_valid, busy, done, and
// spike_total when SPIKE_ENC_COUNT_EN is defined.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int N_PIX   = N_PIX_DEF,
    parameter int PIX_W   = PIX_W_DEF,
    parameter int N_STEPS = N_STEPS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pulse,
    input  logic                   start,
    input  logic [N_PIX*PIX_W-1:0] pixels,
    output logic [N_PIX-1:0]       spike_out,
    output logic                   spike_valid,
    output logic                   busy,
    output logic                   done
`ifdef SPIKE_ENC_COUNT_EN
    , output logic [SPK_CNT_W-1:0] spike_total
`endif
);

    localparam logic [15:0] LAST_STEP = 16'(N_STEPS - 1);

    enc_state_t       state_q, state_d;
    logic [15:0]      step_cnt_q, step_cnt_d;
    logic [N_PIX-1:0] spike_q, spike_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;
    logic             step;
    logic [N_PIX-1:0] spk_next;

    for (genvar i = 0; i < N_PIX; i++) begin : g_ch
        spike_enc_channel #(
            .PIX_W (PIX_W)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .load   (load),
            .step   (step),
            .pix_in (pixels[i*PIX_W +: PIX_W]),
            .spike  (spk_next[i])
        );
    end

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        spike_d    = spike_q;
        valid_d    = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A pulse landing with start is not a timestep.
                if (start) begin
                    load       = 1'b1;
                    step_cnt_d = '0;
                    spike_d    = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (pulse) begin
                    step       = 1'b1;
                    valid_d    = 1'b1;
                    spike_d    = spk_next;
                    step_cnt_d = step_cnt_q + 16'd1;
                    if (step_cnt_q == LAST_STEP) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Last vector stays visible during DONE, cleared on exit.
                spike_d = '0;
                state_d = IDLE;
            end
            default: begin
                spike_d = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            spike_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            spike_q    <= spike_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign spike_out   = spike_q;
    assign spike_valid = valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef SPIKE_ENC_COUNT_EN
    localparam int POP_W = $clog2(N_PIX + 1);

    logic [SPK_CNT_W-1:0] total_q, total_d;
    logic [POP_W-1:0]     pop;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_PIX; i++) begin
            pop = pop + POP_W'(spk_next[i]);
        end
    end

    always_comb begin
        total_d = total_q;
        if (load) begin
            total_d = '0;
        end else if (step) begin
            total_d = sat_add(total_q, SPK_CNT_W'(pop));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign spike_total = total_q;
`endif

endmodule
